// File: rtl/obs_pkg.sv
// Shared constants, state encoding and parameter helpers for the OBS multiplier datapath.
package obs_pkg;

    localparam int M      = 193;        // field degree
    localparam int PROD_W = 2 * M - 1;  // unreduced product width (385)
    localparam int TAP    = 15;         // middle term of x^193 + x^15 + 1

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FOLD = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Number of fold cycles needed to clear bits [384:193].
    function automatic int ncyc(input int fold);
        return (M - 1) / fold;
    endfunction

    // A fold width is usable when it tiles the 192 high bits and keeps every
    // target below the chunk being folded.
    function automatic bit fold_legal(input int fold);
        return (fold >= 1) && (fold <= 96) && (((M - 1) % fold) == 0);
    endfunction

endpackage

// File: rtl/gf2m_fold_slice.sv
// One combinational reduction step: clears the FOLD-bit chunk ending at bit
// hi and XORs it back in at offsets -193 (x^0 term) and -178 (x^15 term).
module gf2m_fold_slice
    import obs_pkg::*;
#(
    parameter int FOLD = 32
) (
    input  logic [PROD_W-1:0] r,
    input  logic [8:0]        hi,
    output logic [PROD_W-1:0] r_next
);

    localparam logic [PROD_W-1:0] MASK = {{(PROD_W - FOLD){1'b0}}, {FOLD{1'b1}}};

    logic [8:0]        lo_s;
    logic [PROD_W-1:0] chunk_s;

    // Extract the chunk, clear it in place and fold it onto both lower taps.
    always_comb begin
        lo_s    = hi - 9'(FOLD - 1);
        chunk_s = (r >> lo_s) & MASK;
        r_next  = (r & ~(MASK << lo_s))
                ^ (chunk_s << (lo_s - 9'(M)))
                ^ (chunk_s << (lo_s - 9'(M - TAP)));
    end

endmodule

// File: rtl/gf2m_reduce_193bit.sv
// Sequential reduction of a 385-bit GF(2) product modulo x^193 + x^15 + 1,
// folding FOLD high-order bits per cycle behind a valid/ready handshake.
module gf2m_reduce_193bit
    import obs_pkg::*;
#(
    parameter int FOLD = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [M-1:0]      out_data,
    output logic              busy
);

    localparam int NCYC  = ncyc(FOLD);
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

    generate
        if (!fold_legal(FOLD)) begin : g_bad_fold
            $error("gf2m_reduce_193bit: FOLD must divide 192 and be <= 96");
        end
    endgenerate

    state_e            state_r;
    state_e            state_next_s;
    logic [PROD_W-1:0] r_r;
    logic [PROD_W-1:0] r_next_s;
    logic [PROD_W-1:0] fold_out_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [8:0]        hi_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;

    // Top bit of the chunk folded in the current cycle.
    always_comb begin
        hi_s = 9'(PROD_W - 1 - (int'(cnt_r) * FOLD));
    end

    gf2m_fold_slice #(
        .FOLD (FOLD)
    ) u_fold_slice (
        .r      (r_r),
        .hi     (hi_s),
        .r_next (fold_out_s)
    );

    // Next-state, accumulator and counter selection.
    always_comb begin
        state_next_s = state_r;
        r_next_s     = r_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    r_next_s     = in_data;
                    cnt_next_s   = '0;
                    state_next_s = S_FOLD;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_FOLD: begin
                r_next_s = fold_out_s;
                if (cnt_r == CNT_W'(NCYC - 1)) begin
                    cnt_next_s   = '0;
                    state_next_s = S_DONE;
                end else begin
                    cnt_next_s   = cnt_r + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // State, datapath and registered handshake outputs; reset discards any work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            r_r         <= '0;
            cnt_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            r_r         <= r_next_s;
            cnt_r       <= cnt_next_s;
            in_ready_r  <= (state_next_s == S_IDLE);
            out_valid_r <= (state_next_s == S_DONE);
            busy_r      <= (state_next_s != S_IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = r_r[M-1:0];

endmodule

// File: tb/tb_gf2m_reduce_193bit.sv
// Directed and randomized checks of the 193-bit trinomial reduction stage.
module tb_gf2m_reduce_193bit;

    localparam int FOLD = 32;
    localparam int NCYC = 192 / FOLD;
    localparam int PW   = 385;
    localparam int MW   = 193;

    typedef struct {
        string         name;
        logic [PW-1:0] din;
        logic [MW-1:0] exp;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] out_data;
    logic          busy;

    int checks;
    int failures;

    gf2m_reduce_193bit #(.FOLD(FOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bitwise top-down reduction, one bit at a time.
    function automatic logic [MW-1:0] ref_reduce(input logic [PW-1:0] d);
        logic [PW-1:0] t;
        t = d;
        for (int i = PW - 1; i >= MW; i--) begin
            if (t[i]) begin
                t[i]        = 1'b0;
                t[i - 193] ^= 1'b1;
                t[i - 178] ^= 1'b1;
            end
        end
        return t[MW-1:0];
    endfunction

    // Accept one product, wait for the result (with optional stalls), then drain it.
    task automatic run_vec(input string name, input logic [PW-1:0] din,
                           input logic [MW-1:0] exp, input bit stalls);
        int lat;
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        chk({name, "_in_ready"}, PW'(in_ready), PW'(1'b1));
        in_valid = 1'b1;
        in_data  = din;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        chk({name, "_busy"}, PW'(busy), PW'(1'b1));
        lat = 0;
        while (!out_valid && lat < 400) begin
            step();
            lat++;
        end
        chk({name, "_latency"}, PW'(lat), PW'(NCYC));
        chk({name, "_data"}, PW'(out_data), PW'(exp));
        chk({name, "_upper_clear"}, PW'(dut.r_r[PW-1:MW]), PW'(0));
        if (stalls) begin
            w = 0;
            out_ready = 1'($urandom_range(0, 1));
            while (!out_ready && w < 20) begin
                step();
                w++;
                out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
            chk({name, "_stall_data"}, PW'(out_data), PW'(exp));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "_idle_ready"}, PW'({in_ready, out_valid}), PW'(2'b10));
    endtask

    initial begin
        vec_t          vecs[6];
        logic [PW-1:0] d;
        logic [MW-1:0] e;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        d = '0; d[193] = 1'b1; e = '0; e[15] = 1'b1; e[0] = 1'b1;
        vecs[0] = '{"x193", d, e};
        d = '0; d[384] = 1'b1; e = '0; e[191] = 1'b1; e[28] = 1'b1; e[13] = 1'b1;
        vecs[1] = '{"x384", d, e};
        d = PW'(16'h1234); e = MW'(16'h1234);
        vecs[2] = '{"low_only", d, e};
        d = '0; d[192] = 1'b1; e = '0; e[192] = 1'b1;
        vecs[3] = '{"x192", d, e};
        d = '0; d[200] = 1'b1; e = '0; e[22] = 1'b1; e[7] = 1'b1;
        vecs[4] = '{"x200", d, e};
        d = '0; d[193] = 1'b1; d[0] = 1'b1; e = '0; e[15] = 1'b1;
        vecs[5] = '{"x193_plus1", d, e};

        step();
        step();
        rst = 1'b0;
        chk("reset_in_ready", PW'(in_ready), PW'(1'b1));
        chk("reset_out_valid", PW'(out_valid), PW'(1'b0));
        chk("reset_busy", PW'(busy), PW'(1'b0));
        chk("reset_out_data", PW'(out_data), PW'(0));

        for (int v = 0; v < 6; v++) begin
            run_vec(vecs[v].name, vecs[v].din, vecs[v].exp, 1'b0);
        end

        // Backpressure: result and handshake hold while in_valid pulses are ignored.
        d = '0; d[384] = 1'b1;
        e = '0; e[191] = 1'b1; e[28] = 1'b1; e[13] = 1'b1;
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < NCYC; c++) step();
        chk("bp_out_valid", PW'(out_valid), PW'(1'b1));
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            in_data  = PW'(32'hdead_0000 + c);
            step();
            chk("bp_hold", PW'({out_valid, in_ready, out_data}), PW'({1'b1, 1'b0, e}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release", PW'({in_ready, out_valid, busy}), PW'(3'b100));

        // Reset in the middle of a fold discards the product.
        d = '0; d[300] = 1'b1;
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) step();
        chk("midfold_cnt", PW'(dut.cnt_r), PW'(3));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_fold", PW'({in_ready, out_valid, busy}), PW'(3'b100));
        chk("rst_out_data", PW'(out_data), PW'(0));
        d = '0; d[384] = 1'b1; d[193] = 1'b1;
        e = '0; e[191] = 1'b1; e[28] = 1'b1; e[13] = 1'b1; e[15] = 1'b1; e[0] = 1'b1;
        run_vec("after_rst", d, e, 1'b0);

        // Random products against the bitwise model, with random consumer stalls.
        for (int n = 0; n < 200; n++) begin
            d = '0;
            for (int k = 0; k < 13; k++) d = (d << 32) | PW'($urandom());
            run_vec("random", d, ref_reduce(d), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gf2m_reduce_193bit.md
# gf2m_reduce_193bit

Sequential modular-reduction stage for the 193-bit binary-field multiplier. It accepts the unreduced 385-bit polynomial product assembled by the overlap/recombination stages and reduces it modulo the trinomial f(x) = x^193 + x^15 + 1. The reduction folds FOLD high-order bits per cycle and returns the 193-bit field element over a valid/ready handshake. It is the final stage of the OBS multiplier datapath.

## Interface
- FOLD, default 32: bits folded per cycle. Legal values are divisors of 192 that are ≤ 96 (1,2,3,4,6,8,12,16,24,32,48,64,96). Any other value is an elaboration error.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a product.
- in_data  input  385  unreduced product, bit i = coefficient of x^i.
- out_valid  output  1  out_data holds a reduced result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  193  reduced element, bit i = coefficient of x^i.
- busy  output  1  high in FOLD or DONE.

## Operation
- Internal accumulator r[384:0], fold counter cnt (0..NCYC-1), where NCYC = 192/FOLD.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready: r<=in_data, cnt<=0, go to FOLD.
  - FOLD: each cycle, hi = 384 - cnt*FOLD. Every bit i in [hi-FOLD+1, hi] with r[i]=1 is cleared and XORed into r[i-193] and r[i-178]. All FOLD bits in a cycle are handled in parallel. The targets always lie below the current chunk because FOLD ≤ 178. cnt increments each cycle. After the fold with cnt=NCYC-1, go to DONE.
  - DONE: out_valid=1, out_data=r[192:0]. On out_ready, go to IDLE.
- Bits landing in [193,206] from folds of i ≥ 371 are cleared by later chunks. After NCYC folds, r[384:193] = 0. This is a verification assertion.
- Inputs with in_data[384:193]=0 still take the full NCYC cycles. There is no early exit.
- in_valid is ignored outside IDLE. in_data is sampled only on the accept edge.
- Arithmetic is pure GF(2): XOR only, no carries.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, r=0, cnt=0.
- Accept edge at cycle k. out_valid rises at the edge k+NCYC (NCYC=6 at default).
- While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
- out_valid && out_ready at edge j: state is IDLE with in_ready=1 at j+1. Best-case throughput is one result per NCYC+2 cycles.
- in_ready is low from the accept edge until the IDLE return. A simultaneous in_valid during DONE is not accepted.
- rst asserted in any state overrides everything at that edge: all reset values apply, and any in-flight product is discarded with no out_valid.

## Structure
- Shared package obs_pkg: M=193, PROD_W=2*M-1=385, TAP=15, NCYC function of FOLD, and the state enum {IDLE, FOLD, DONE}.
- One natural sub-module, gf2m_fold_slice. It is combinational and takes r and hi, producing the next r for one FOLD-bit chunk. The top level holds the FSM, counter and registers.

## Test plan
- in_data=x^193 (bit 193 only) → out_data=0x8001 (x^15+1) after 6 cycles at FOLD=32.
- in_data=x^384 → out_data = x^191 + x^28 + x^13.
- in_data=0x1234 (upper bits zero) → out_data=0x1234, out_valid exactly NCYC cycles after accept.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_data stable, in_ready=0, in_valid pulses ignored. Release → IDLE next cycle.
- rst pulsed in FOLD at cnt=3 → next cycle in_ready=1, out_valid=0. A new product then reduces correctly.
- 10k random 385-bit products at each of FOLD=1, 32, 96, compared against a software bitwise reduction model. Random out_ready stalls; assert r[384:193]=0 in DONE.
